// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package muldiv_sequencer_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = $clog2(XLEN) + 1;

    // M-extension funct3 encodings handled by the unit
    localparam logic [2:0] F3_MUL  = 3'b000;
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [XLEN-1:0] sext_word(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext_word(input logic [31:0] v);
        return {{(XLEN-32){1'b0}}, v};
    endfunction

    // Word results are always sign-extended from bit 31, unsigned ops included.
    function automatic logic [XLEN-1:0] fmt_result(input logic word, input logic [XLEN-1:0] v);
        return word ? sext_word(v[31:0]) : v;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage <-> mul/div unit handshake bundle.
interface muldiv_sequencer_if;
    import muldiv_sequencer_pkg::*;

    logic            flush;
    logic            op_valid;
    logic            op_ready;
    logic [2:0]      op_funct3;
    logic            op_word;
    logic [XLEN-1:0] op_src1;
    logic [XLEN-1:0] op_src2;
    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] res_data;
    logic            busy;

    modport master (
        output flush, op_valid, op_funct3, op_word, op_src1, op_src2, res_ready,
        input  op_ready, res_valid, res_data, busy
    );

    modport slave (
        input  flush, op_valid, op_funct3, op_word, op_src1, op_src2, res_ready,
        output op_ready, res_valid, res_data, busy
    );

endinterface

// File: rtl/muldiv_div_core.sv
// Restoring radix-2 divide datapath on unsigned magnitudes; one quotient bit per step.
// The dividend is expected MSB-aligned in the quotient register so word ops
// simply run fewer steps. quo_nxt/rem_nxt expose the post-step values so the
// caller can capture the final result in the same cycle as the last step.
module muldiv_div_core
    import muldiv_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            clr,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo_nxt,
    output logic [XLEN-1:0] rem_nxt
);

    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            q_bit;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        q_bit   = ~diff[XLEN];
        rem_nxt = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_nxt = {quo_q[XLEN-2:0], q_bit};
    end

    // Remainder/quotient shift registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (step) begin
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit with its own sequencing FSM.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | ready for a new op (op_ready = 1)
//   S_MUL  | shift-add multiply, one multiplier bit per cycle
//   S_DIV  | restoring divide, one quotient bit per cycle
//   S_DONE | result held on res_data until res_ready
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    muldiv_sequencer_if.slave bus
);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              accept;

    logic              in_is_div, in_signed, in_rem;
    logic [XLEN-1:0]   src1_w, src2_w, min_w;
    logic              div_zero, div_ovf, fast;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN-1:0]   fast_raw, fast_res;

    logic              word_q, is_rem_q, neg_q_q, neg_r_q;
    logic [XLEN-1:0]   mcand, mplier, prod, prod_nxt;
    logic [XLEN-1:0]   quo_nxt, rem_nxt, q_fix, r_fix;
    logic [XLEN-1:0]   res_q, res_val;

    logic              cnt_load, cnt_dec, mul_load, mul_step, div_load, div_step;
    logic              res_load, res_clr;

    assign accept = bus.op_valid && bus.op_ready && !bus.flush;

    // funct3[2] selects divide; other non-mul encodings fall through to mul.
    assign in_is_div = bus.op_funct3[2];
    assign in_signed = ~bus.op_funct3[0];
    assign in_rem    = bus.op_funct3[1];

    // Bring word operands to full width so a single compare/negate path serves both widths.
    assign src1_w = bus.op_word ? (in_signed ? sext_word(bus.op_src1[31:0]) : zext_word(bus.op_src1[31:0]))
                                : bus.op_src1;
    assign src2_w = bus.op_word ? (in_signed ? sext_word(bus.op_src2[31:0]) : zext_word(bus.op_src2[31:0]))
                                : bus.op_src2;
    assign min_w  = bus.op_word ? sext_word(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};

    assign div_zero = (src2_w == '0);
    assign div_ovf  = in_signed && (src1_w == min_w) && (src2_w == '1);
    assign fast     = in_is_div && (div_zero || div_ovf);

    assign neg_a = in_signed && src1_w[XLEN-1];
    assign neg_b = in_signed && src2_w[XLEN-1];
    assign mag_a = neg_a ? -src1_w : src1_w;
    assign mag_b = neg_b ? -src2_w : src2_w;

    // Results for the divide-by-zero and signed-overflow cases, ready in the accept cycle.
    always_comb begin
        fast_raw = '0;
        if (div_zero) fast_raw = in_rem ? src1_w : '1;
        else          fast_raw = in_rem ? '0 : src1_w;
        fast_res = fmt_result(bus.op_word, fast_raw);
    end

    assign prod_nxt = prod + (mplier[0] ? mcand : '0);

    // Sign fixup on the final divide step; remainder follows the dividend's sign.
    assign q_fix = neg_q_q ? -quo_nxt : quo_nxt;
    assign r_fix = neg_r_q ? -rem_nxt : rem_nxt;

    // State register; flush and reset both return to idle.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) state <= S_IDLE;
        else                  state <= state_nxt;
    end

    // Next-state and datapath control.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        mul_load  = 1'b0;
        mul_step  = 1'b0;
        div_load  = 1'b0;
        div_step  = 1'b0;
        res_load  = 1'b0;
        res_clr   = 1'b0;
        res_val   = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (fast) begin
                        state_nxt = S_DONE;
                        res_load  = 1'b1;
                        res_val   = fast_res;
                    end else if (in_is_div) begin
                        state_nxt = S_DIV;
                        div_load  = 1'b1;
                        cnt_load  = 1'b1;
                    end else begin
                        state_nxt = S_MUL;
                        mul_load  = 1'b1;
                        cnt_load  = 1'b1;
                    end
                end
            end
            S_MUL: begin
                mul_step = 1'b1;
                cnt_dec  = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_DONE;
                    res_load  = 1'b1;
                    res_val   = fmt_result(word_q, prod_nxt);
                end
            end
            S_DIV: begin
                div_step = 1'b1;
                cnt_dec  = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_DONE;
                    res_load  = 1'b1;
                    res_val   = fmt_result(word_q, is_rem_q ? r_fix : q_fix);
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_nxt = S_IDLE;
                    res_clr   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Iteration counter, loaded with the operand width at accept.
    always_ff @(posedge clk) begin
        if (rst || bus.flush)  cnt <= '0;
        else if (cnt_load)     cnt <= bus.op_word ? CNT_W'(32) : CNT_W'(XLEN);
        else if (cnt_dec)      cnt <= cnt - CNT_W'(1);
    end

    // Op attributes captured at accept so later operand changes have no effect.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            word_q   <= 1'b0;
            is_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else if (accept) begin
            word_q   <= bus.op_word;
            is_rem_q <= in_rem;
            neg_q_q  <= neg_a ^ neg_b;
            neg_r_q  <= neg_a;
        end
    end

    // Shift-add multiplier; low bits are sign-agnostic so raw operands are used.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
        end else if (mul_load) begin
            mcand  <= bus.op_src1;
            mplier <= bus.op_src2;
            prod   <= '0;
        end else if (mul_step) begin
            mcand  <= {mcand[XLEN-2:0], 1'b0};
            mplier <= {1'b0, mplier[XLEN-1:1]};
            prod   <= prod_nxt;
        end
    end

    // Result register: written on entry to S_DONE, zero otherwise.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) res_q <= '0;
        else if (res_load)    res_q <= res_val;
        else if (res_clr)     res_q <= '0;
    end

    muldiv_div_core u_div_core (
        .clk      (clk),
        .clr      (rst || bus.flush),
        .load     (div_load),
        .step     (div_step),
        .dividend (bus.op_word ? {mag_a[31:0], 32'h0} : mag_a),
        .divisor  (mag_b),
        .quo_nxt  (quo_nxt),
        .rem_nxt  (rem_nxt)
    );

    assign bus.op_ready  = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.res_valid = (state == S_DONE);
    assign bus.res_data  = res_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with hand-computed results.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    muldiv_sequencer_if bus();

    muldiv_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present an op for one accept edge, then scramble the operands.
    task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        bus.op_valid  = 1'b1;
        bus.op_funct3 = f3;
        bus.op_word   = w;
        bus.op_src1   = a;
        bus.op_src2   = b;
        @(posedge clk);
        #1;
        bus.op_valid  = 1'b0;
        bus.op_src1   = 64'hA5A5_5A5A_0F0F_F0F0;
        bus.op_src2   = 64'h0123_4567_89AB_CDEF;
        bus.op_funct3 = 3'b000;
        bus.op_word   = 1'b0;
    endtask

    // Count cycles after accept until res_valid; 999 marks a timeout.
    task automatic wait_res(output int lat, output logic rdy_low);
        lat     = 0;
        rdy_low = 1'b1;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (bus.res_valid) break;
            if (bus.op_ready) rdy_low = 1'b0;
        end
        if (!bus.res_valid) lat = 999;
    endtask

    task automatic consume();
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input int exp_lat);
        int   lat;
        logic rdy_low;
        issue(f3, w, a, b);
        wait_res(lat, rdy_low);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_data"}, bus.res_data, exp_res);
        if (exp_lat > 1) chk({tag, "_rdy_low"}, 64'(rdy_low), 64'd1);
        consume();
    endtask

    initial begin
        int   lat;
        logic rdy_low;
        logic seen;
        total = 0;
        bad   = 0;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.op_valid  = 1'b0;
        bus.op_funct3 = 3'b000;
        bus.op_word   = 1'b0;
        bus.op_src1   = '0;
        bus.op_src2   = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_op_ready", 64'(bus.op_ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_res_data", bus.res_data, 64'd0);

        run_op("mul64", F3_MUL, 1'b0, 64'h0000_0001_0000_0003, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFE_FFFF_FFFD, 65);
        run_op("divw", F3_DIV, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 33);
        run_op("remw", F3_REM, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'h7777_0000_0000_0002,
               64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("divu0", F3_DIVU, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("remu0", F3_REMU, 1'b0, 64'h1234, 64'd0, 64'h1234, 1);
        run_op("div_ovf", F3_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1);
        run_op("rem_ovf", F3_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd0, 1);
        run_op("divuw", F3_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1,
               64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("div64", F3_DIV, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9,
               64'hFFFF_FFFF_FFFF_FFF2, 65);
        run_op("rem64", F3_REM, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65);
        run_op("mulw", F3_MUL, 1'b1, 64'h1234_5678_0001_0000, 64'h0000_0000_0001_0000, 64'd0, 33);

        // Back-pressure: result held while res_ready low, no accept until release.
        issue(F3_MUL, 1'b0, 64'd3, 64'd5);
        wait_res(lat, rdy_low);
        chk("bp_lat", 64'(lat), 64'd65);
        bus.op_valid  = 1'b1;
        bus.op_funct3 = F3_DIVU;
        bus.op_word   = 1'b0;
        bus.op_src1   = 64'h55;
        bus.op_src2   = 64'd0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_data", bus.res_data, 64'd15);
            chk("bp_hold_rdy", 64'(bus.op_ready), 64'd0);
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        @(negedge clk);
        chk("bp_rel_rdy", 64'(bus.op_ready), 64'd1);
        chk("bp_rel_valid", 64'(bus.res_valid), 64'd0);
        chk("bp_rel_data", bus.res_data, 64'd0);
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_valid", 64'(bus.res_valid), 64'd1);
        chk("bp_next_data", bus.res_data, 64'hFFFF_FFFF_FFFF_FFFF);
        consume();

        // Flush during a divide: back to idle, no result ever appears.
        issue(F3_DIV, 1'b0, 64'd1000, 64'd7);
        repeat (20) @(negedge clk);
        chk("fl_busy_before", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        chk("fl_busy", 64'(bus.busy), 64'd0);
        chk("fl_rdy", 64'(bus.op_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (bus.res_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("fl_no_result", 64'(seen), 64'd0);

        // Flush and op_valid together in idle: no accept.
        bus.flush     = 1'b1;
        bus.op_valid  = 1'b1;
        bus.op_funct3 = F3_MUL;
        bus.op_src1   = 64'd2;
        bus.op_src2   = 64'd2;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.op_valid = 1'b0;
        @(negedge clk);
        chk("fl_idle_busy", 64'(bus.busy), 64'd0);
        chk("fl_idle_rdy", 64'(bus.op_ready), 64'd1);

        // Reset in the middle of a multiply.
        issue(F3_MUL, 1'b0, 64'd9, 64'd9);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rm_rdy", 64'(bus.op_ready), 64'd1);
        chk("rm_busy", 64'(bus.busy), 64'd0);
        chk("rm_valid", 64'(bus.res_valid), 64'd0);
        chk("rm_data", bus.res_data, 64'd0);

        run_op("mul_after", F3_MUL, 1'b0, 64'd7, 64'd6, 64'd42, 65);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle iterative multiply/divide unit with its own sequencing FSM.
- Replaces the single-cycle `*`, `/` and `%` paths in the execute stage.
- Execute accepts an M-extension op, drops its ready_go until the result returns, then forwards the result on the ex→mem bus.
- Also stalls on mem_allowin back-pressure and is cancelled by pipeline flush.

Parameters:
- XLEN, 64: operand/result width; word ops use XLEN/2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  cancel in-flight op; no result is produced
- op_valid  in  1  execute presents an op
- op_ready  out  1  unit can accept an op (state IDLE)
- op_funct3  in  3  000 mul, 100 div, 101 divu, 110 rem, 111 remu; others are illegal and treated as mul
- op_word  in  1  W-variant (mulw/divw/divuw/remw/remuw)
- op_src1  in  XLEN  rs1 value
- op_src2  in  XLEN  rs2 value
- res_valid  out  1  result held valid
- res_ready  in  1  execute consumes result
- res_data  out  XLEN  result
- busy  out  1  state != IDLE

Behaviour:
- Reset and flush both force: state IDLE, res_valid 0, res_data 0, busy 0, op_ready 1, counter 0.
- Flush has priority over op_valid: no accept in a flush cycle.
- Reset mid-operation discards all internal state.
- Accept happens when op_valid && op_ready. The unit latches funct3, word, operands, and the derived sign flags.
- Width rule: W = word ? 32 : XLEN. Word ops use only bits [31:0] of the operands.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE → DONE (fast path, next cycle) when:
  - divide/rem with divisor (low W bits) == 0: quotient = all ones; remainder = dividend.
  - signed div/rem with dividend = −2^(W−1) and divisor = −1: quotient = dividend; remainder = 0.
- IDLE → MUL for funct3 000. IDLE → DIV otherwise. Counter loads W.
- MUL: radix-2 shift-add, one multiplier bit per cycle, low W bits of the product only.
  - Signedness is irrelevant for low bits, so operands are used raw.
  - Counter decrements each cycle; on counter == 1 → DONE.
- DIV: restoring radix-2 on magnitudes, one quotient bit per cycle, W cycles, then → DONE.
  - div/rem take absolute values first. divu/remu use raw values.
  - Sign fixup: negate the quotient if the operand signs differ (signed ops only); the remainder takes the dividend's sign.
  - Fixup is applied in the transition cycle into DONE, not as an extra state.
- DONE: res_valid = 1; res_data holds stable until res_ready. On res_valid && res_ready → IDLE.
  - op_ready stays 0 in DONE, so there is no back-to-back accept; minimum issue spacing is latency + 1.
- Word results are sign-extended from bit 31, divuw/remuw included (RISC-V rule).
- Latency from the accept cycle (cycle 0) to the first res_valid cycle:
  - W + 1 cycles for MUL/DIV (65 for 64-bit, 33 for word).
  - 1 cycle for fast-path cases.
- res_data = 0 whenever res_valid = 0.
- op_src* may change after accept without affecting the result.

Decomposition:
- Shared package/header holds:
  - funct3 encodings for the M ops;
  - FSM state encodings (2-bit localparams IDLE = 0, MUL = 1, DIV = 2, DONE = 3);
  - XLEN.
- One sub-module, muldiv_div_core: the restoring-divide iteration datapath (remainder/quotient shift registers, one step per enable). The FSM, fast paths, sign fixup and the multiplier stay in the top.

Test Plan:
- mul 64-bit, src1 = 0x0000_0001_0000_0003, src2 = 0xFFFF_FFFF_FFFF_FFFF → res_data 0xFFFF_FFFE_FFFF_FFFD; res_valid exactly 65 cycles after accept; op_ready 0 throughout.
- divw src1 = 0x…FFFF_FFF9 (−7), src2 = 2 → 0xFFFF_FFFF_FFFF_FFFD (−3); remw on the same operands → 0xFFFF_FFFF_FFFF_FFFF (−1); latency 33.
- divu by 0, src1 = 0x1234 → 0xFFFF_FFFF_FFFF_FFFF; remu by 0 → 0x1234; both with latency 1.
- div src1 = 0x8000_0000_0000_0000, src2 = −1 → quotient 0x8000_0000_0000_0000, rem 0; latency 1. divuw src1 = 0xFFFF_FFFF, src2 = 1 → 0xFFFF_FFFF_FFFF_FFFF (sign-extended).
- Hold res_ready = 0 for 10 cycles after res_valid → res_data stable, no new accept despite op_valid = 1; release → IDLE next cycle, then accept.
- Assert flush at iteration 20 of a div → next cycle IDLE, res_valid never rises. Flush + op_valid in the same IDLE cycle → no accept. rst mid-mul → all outputs at reset values next cycle.
